gps_signal_gen: RTL and testbench

Synthetic GPS L1 C/A baseband sample source: produces the same `data`/`data_available` stream a subchannel consumes. Each sample is the BPSK product of the C/A chip for a programmable PRN, a 50 bps navigation bit, and the sign of a quadrant carrier NCO. It is used to drive tracking channels in simulation and hardware loopback without an RF front end.

---
 rtl/gps_signal_gen_pkg.sv | 53 +++++
 rtl/gps_signal_gen_ca_generator.sv | 50 +++++
 rtl/gps_signal_gen.sv | 119 +++++++++++
 tb/tb_gps_signal_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gps_signal_gen_pkg.sv
// Shared constants and the G2 tap-pair table for the GPS L1 C/A signal generator.
package gps_signal_gen_pkg;

  localparam int CA_LENGTH      = 1023;
  localparam int EPOCHS_PER_BIT = 20;

  // G2 register stages (1-based) XORed to form the PRN-specific G2 output
  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
  } tap_pair_t;

  function automatic tap_pair_t g2_taps(input logic [4:0] prn);
    tap_pair_t t;
    case (prn)
      5'd0:    t = '{4'd2, 4'd6};
      5'd1:    t = '{4'd3, 4'd7};
      5'd2:    t = '{4'd4, 4'd8};
      5'd3:    t = '{4'd5, 4'd9};
      5'd4:    t = '{4'd1, 4'd9};
      5'd5:    t = '{4'd2, 4'd10};
      5'd6:    t = '{4'd1, 4'd8};
      5'd7:    t = '{4'd2, 4'd9};
      5'd8:    t = '{4'd3, 4'd10};
      5'd9:    t = '{4'd2, 4'd3};
      5'd10:   t = '{4'd3, 4'd4};
      5'd11:   t = '{4'd5, 4'd6};
      5'd12:   t = '{4'd6, 4'd7};
      5'd13:   t = '{4'd7, 4'd8};
      5'd14:   t = '{4'd8, 4'd9};
      5'd15:   t = '{4'd9, 4'd10};
      5'd16:   t = '{4'd1, 4'd4};
      5'd17:   t = '{4'd2, 4'd5};
      5'd18:   t = '{4'd3, 4'd6};
      5'd19:   t = '{4'd4, 4'd7};
      5'd20:   t = '{4'd5, 4'd8};
      5'd21:   t = '{4'd6, 4'd9};
      5'd22:   t = '{4'd1, 4'd3};
      5'd23:   t = '{4'd4, 4'd6};
      5'd24:   t = '{4'd5, 4'd7};
      5'd25:   t = '{4'd6, 4'd8};
      5'd26:   t = '{4'd7, 4'd9};
      5'd27:   t = '{4'd8, 4'd10};
      5'd28:   t = '{4'd1, 4'd6};
      5'd29:   t = '{4'd2, 4'd7};
      5'd30:   t = '{4'd3, 4'd8};
      5'd31:   t = '{4'd4, 4'd9};
      default: t = '{4'd2, 4'd6};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/gps_signal_gen_ca_generator.sv
// C/A code generator: G1/G2 LFSRs with PRN tap select and chip index, reusable on the receive side.
module ca_generator
  import gps_signal_gen_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_step,
  input  logic       i_reload,
  input  logic [4:0] i_prn,
  output logic       o_chip,
  output logic [9:0] o_index,
  output logic       o_wrap
);

  logic [9:0]  r_g1;
  logic [9:0]  r_g2;
  logic [9:0]  r_index;
  logic        w_last;
  tap_pair_t   w_taps;
  logic [15:0] w_g2_ext;
  logic [3:0]  w_sel1;
  logic [3:0]  w_sel2;

  assign w_last   = (r_index == 10'(CA_LENGTH - 1));
  assign w_taps   = g2_taps(i_prn);
  assign w_g2_ext = {6'd0, r_g2};
  assign w_sel1   = w_taps.s1 - 4'd1;
  assign w_sel2   = w_taps.s2 - 4'd1;
  assign o_chip   = r_g1[9] ^ w_g2_ext[w_sel1] ^ w_g2_ext[w_sel2];
  assign o_index  = r_index;
  assign o_wrap   = i_step && w_last;

  // Bit n holds stage n+1; a period wrap reloads all-ones so each period restarts exactly
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_g1    <= 10'h3FF;
      r_g2    <= 10'h3FF;
      r_index <= 10'd0;
    end else if (i_reload || (i_step && w_last)) begin
      r_g1    <= 10'h3FF;
      r_g2    <= 10'h3FF;
      r_index <= 10'd0;
    end else if (i_step) begin
      r_g1    <= {r_g1[8:0], r_g1[2] ^ r_g1[9]};
      r_g2    <= {r_g2[8:0], r_g2[1] ^ r_g2[2] ^ r_g2[5] ^ r_g2[7] ^ r_g2[8] ^ r_g2[9]};
      r_index <= r_index + 10'd1;
    end
  end

endmodule

// File: rtl/gps_signal_gen.sv
// Synthetic GPS L1 C/A baseband source: BPSK of C/A chip, 50 bps nav bit and quadrant carrier sign.
module gps_signal_gen
  import gps_signal_gen_pkg::*;
#(
  parameter int SAMPLE_DIV = 4,
  parameter int OUT_WIDTH  = 3,
  parameter int AMPLITUDE  = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_start,
  input  logic [4:0]           i_prn,
  input  logic [31:0]          i_code_rate,
  input  logic [31:0]          i_carrier_rate,
  input  logic                 i_nav_bit,
  output logic                 o_nav_taken,
  output logic                 o_data_available,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_ca_bit,
  output logic [9:0]           o_ca_code_shift,
  output logic                 o_epoch
);

  localparam int                   TIMER_W    = $clog2(SAMPLE_DIV);
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(SAMPLE_DIV - 1);
  localparam logic [OUT_WIDTH-1:0] POS_SAMPLE = OUT_WIDTH'(AMPLITUDE);
  localparam logic [OUT_WIDTH-1:0] NEG_SAMPLE = OUT_WIDTH'(-AMPLITUDE);

  logic [TIMER_W-1:0]   r_timer;
  logic [31:0]          r_code_phase;
  logic [31:0]          r_carr_phase;
  logic [4:0]           r_epoch_cnt;
  logic [4:0]           r_prn;
  logic                 r_nav;
  logic                 r_data_available;
  logic [OUT_WIDTH-1:0] r_data;
  logic                 r_epoch;
  logic                 r_nav_taken;

  logic        w_tick;
  logic [32:0] w_code_sum;
  logic        w_chip;
  logic [9:0]  w_index;
  logic        w_wrap;
  logic        w_nav_bound;
  logic        w_neg;

  // start wins over a tick landing in the same cycle
  assign w_tick      = i_enable && !i_start && (r_timer == TIMER_LAST);
  assign w_code_sum  = {1'b0, r_code_phase} + {1'b0, i_code_rate};
  assign w_nav_bound = w_wrap && (r_epoch_cnt == 5'(EPOCHS_PER_BIT - 1));
  assign w_neg       = w_chip ^ r_nav ^ (r_carr_phase[31] ^ r_carr_phase[30]);

  ca_generator u_ca (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_step   (w_tick && w_code_sum[32]),
    .i_reload (i_start),
    .i_prn    (r_prn),
    .o_chip   (w_chip),
    .o_index  (w_index),
    .o_wrap   (w_wrap)
  );

  // Sample timer, NCO phases, epoch counter and navigation bit register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer      <= '0;
      r_code_phase <= 32'd0;
      r_carr_phase <= 32'd0;
      r_epoch_cnt  <= 5'd0;
      r_prn        <= 5'd0;
      r_nav        <= 1'b0;
    end else if (i_start) begin
      r_timer      <= '0;
      r_code_phase <= 32'd0;
      r_carr_phase <= 32'd0;
      r_epoch_cnt  <= 5'd0;
      r_prn        <= i_prn;
      r_nav        <= i_nav_bit;
    end else if (w_tick) begin
      r_timer      <= '0;
      r_code_phase <= w_code_sum[31:0];
      r_carr_phase <= r_carr_phase + i_carrier_rate;
      if (w_nav_bound) begin
        r_epoch_cnt <= 5'd0;
        r_nav       <= i_nav_bit;
      end else if (w_wrap) begin
        r_epoch_cnt <= r_epoch_cnt + 5'd1;
      end
    end else if (i_enable) begin
      r_timer <= r_timer + TIMER_W'(1);
    end
  end

  // Output register: sample uses pre-advance state, strobes last one cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data_available <= 1'b0;
      r_data           <= '0;
      r_epoch          <= 1'b0;
      r_nav_taken      <= 1'b0;
    end else begin
      r_data_available <= w_tick;
      r_data           <= w_tick ? (w_neg ? NEG_SAMPLE : POS_SAMPLE) : '0;
      r_epoch          <= w_wrap;
      r_nav_taken      <= i_start || w_nav_bound;
    end
  end

  assign o_data_available = r_data_available;
  assign o_data           = r_data;
  assign o_epoch          = r_epoch;
  assign o_nav_taken      = r_nav_taken;
  assign o_ca_bit         = w_chip;
  assign o_ca_code_shift  = w_index;

endmodule

// File: tb/tb_gps_signal_gen.sv
// Self-checking bench for gps_signal_gen against a chip-count/phase-sum reference model.
module tb_gps_signal_gen;

  localparam int SD  = 2;
  localparam int OW  = 3;
  localparam int AMP = 3;

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_enable = 1'b1;
  logic          i_start = 1'b0;
  logic [4:0]    i_prn = 5'd0;
  logic [31:0]   i_code_rate = 32'h8000_0000;
  logic [31:0]   i_carrier_rate = 32'd0;
  logic          i_nav_bit = 1'b0;
  logic          o_nav_taken;
  logic          o_data_available;
  logic [OW-1:0] o_data;
  logic          o_ca_bit;
  logic [9:0]    o_ca_code_shift;
  logic          o_epoch;

  gps_signal_gen #(.SAMPLE_DIV(SD), .OUT_WIDTH(OW), .AMPLITUDE(AMP)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_start(i_start),
    .i_prn(i_prn), .i_code_rate(i_code_rate), .i_carrier_rate(i_carrier_rate),
    .i_nav_bit(i_nav_bit), .o_nav_taken(o_nav_taken),
    .o_data_available(o_data_available), .o_data(o_data), .o_ca_bit(o_ca_bit),
    .o_ca_code_shift(o_ca_code_shift), .o_epoch(o_epoch)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference C/A codes: Gold code = G1 xor G2 delayed by the PRN's chip delay
  bit ca_tab [32][1023];
  int g2_delay [32] = '{5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256, 257, 258,
                        469, 470, 471, 472, 473, 474, 509, 512, 513, 514, 515, 516, 859, 860, 861, 862};

  longint m_code, m_carr;
  int     m_prn, m_cnt, sample_no, first_epoch, n_nav, nav_at;
  bit     m_nav, nav_alt;
  int     obs_q[$];

  function automatic void build_tables();
    bit g1 [1023];
    bit g2 [1023];
    bit [10:1] s1, s2;
    s1 = '1;
    s2 = '1;
    for (int i = 0; i < 1023; i++) begin
      g1[i] = s1[10];
      g2[i] = s2[10];
      s1 = {s1[9:1], s1[3] ^ s1[10]};
      s2 = {s2[9:1], s2[2] ^ s2[3] ^ s2[6] ^ s2[8] ^ s2[9] ^ s2[10]};
    end
    for (int p = 0; p < 32; p++)
      for (int i = 0; i < 1023; i++)
        ca_tab[p][i] = g1[i] ^ g2[(i - g2_delay[p] + 1023) % 1023];
  endfunction

  function automatic int model_sample();
    int  idx;
    int  quad;
    bit  neg;
    idx  = int'((m_code >> 32) % 1023);
    quad = int'((m_carr >> 30) & 64'd3);
    neg  = ca_tab[m_prn][idx] ^ m_nav ^ (quad == 1 || quad == 2);
    return neg ? -AMP : AMP;
  endfunction

  function automatic void model_restart(input int prn, input bit nav);
    m_code = 0; m_carr = 0; m_prn = prn; m_nav = nav; m_cnt = 0;
    sample_no = 0; first_epoch = -1; n_nav = 0; nav_at = -1;
    obs_q.delete();
  endfunction

  task automatic run_samples(input int n, input int gap_at, input int gap_len);
    int done = 0;
    int gap_left = gap_len;
    bit en;
    int exp_data, got, idx;
    longint c_old, c_new;
    bit exp_ep, exp_nt;
    while (done < n) begin
      en = !(done == gap_at && gap_left > 0);
      if (!en) gap_left--;
      i_enable = en;
      @(posedge clk); #1;
      if (en) m_cnt++;
      if (m_cnt == SD) begin
        m_cnt = 0; done++; sample_no++;
        exp_data = model_sample();
        c_old  = m_code >> 32;
        m_code = m_code + longint'({32'd0, i_code_rate});
        c_new  = m_code >> 32;
        m_carr = (m_carr + longint'({32'd0, i_carrier_rate})) & 64'hFFFF_FFFF;
        exp_ep = (c_new / 1023) != (c_old / 1023);
        exp_nt = (c_new / 20460) != (c_old / 20460);
        if (exp_nt) m_nav = i_nav_bit;
        idx = int'(c_new % 1023);
        got = $signed(o_data);
        n_checks++;
        if (o_data_available !== 1'b1 || got != exp_data || o_epoch !== exp_ep ||
            o_nav_taken !== exp_nt || o_ca_code_shift !== 10'(idx) || o_ca_bit !== ca_tab[m_prn][idx])
          $display("FAIL sample s%0d: got dav=%b data=%0d ep=%b nt=%b idx=%0d chip=%b want dav=1 data=%0d ep=%b nt=%b idx=%0d chip=%b",
                   sample_no, o_data_available, got, o_epoch, o_nav_taken, o_ca_code_shift, o_ca_bit,
                   exp_data, exp_ep, exp_nt, idx, ca_tab[m_prn][idx]);
        else n_pass++;
        obs_q.push_back(got);
        if (o_epoch && first_epoch < 0) first_epoch = sample_no;
        if (o_nav_taken) begin n_nav++; nav_at = sample_no; end
        if (nav_alt) i_nav_bit = ~m_nav;
      end else begin
        n_checks++;
        if (o_data_available !== 1'b0 || o_data !== '0 || o_epoch !== 1'b0 || o_nav_taken !== 1'b0)
          $display("FAIL idle after s%0d: got dav=%b data=%0d ep=%b nt=%b want all 0",
                   sample_no, o_data_available, $signed(o_data), o_epoch, o_nav_taken);
        else n_pass++;
      end
    end
    i_enable = 1'b1;
  endtask

  task automatic do_start(input int prn, input bit nav);
    i_prn = 5'(prn); i_nav_bit = nav; i_start = 1'b1; i_enable = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    model_restart(prn, nav);
    if (nav_alt) i_nav_bit = ~nav;
    n_checks++;
    if (o_data_available !== 1'b0 || o_nav_taken !== 1'b1 || o_ca_code_shift !== 10'd0 || o_ca_bit !== ca_tab[prn][0])
      $display("FAIL start: got dav=%b nt=%b idx=%0d chip=%b want dav=0 nt=1 idx=0 chip=%b",
               o_data_available, o_nav_taken, o_ca_code_shift, o_ca_bit, ca_tab[prn][0]);
    else n_pass++;
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (o_data_available !== 1'b0 || o_data !== '0 || o_nav_taken !== 1'b0 || o_epoch !== 1'b0 ||
        o_ca_code_shift !== 10'd0 || o_ca_bit !== 1'b1)
      $display("FAIL %s: got dav=%b data=%0d nt=%b ep=%b idx=%0d chip=%b want 0 0 0 0 0 1", tag,
               o_data_available, $signed(o_data), o_nav_taken, o_epoch, o_ca_code_shift, o_ca_bit);
    else n_pass++;
  endtask

  task automatic test_reset();
    i_code_rate = 32'h8000_0000; i_carrier_rate = 32'd0; i_nav_bit = 1'b1; i_prn = 5'd9;
    #12;
    check_reset_values("reset_values");
    @(negedge clk);
    i_rst_n = 1'b1;
    model_restart(0, 1'b0);
    run_samples(8, -1, 0);
  endtask

  task automatic test_prn1_pattern();
    int exp6 [6] = '{-3, -3, -3, -3, 3, 3};
    i_code_rate = 32'h8000_0000; i_carrier_rate = 32'd0;
    do_start(0, 1'b0);
    run_samples(20, -1, 0);
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (obs_q[k] != exp6[k]) $display("FAIL prn1_pattern s%0d: got %0d want %0d", k + 1, obs_q[k], exp6[k]);
      else n_pass++;
    end
  endtask

  task automatic test_carrier();
    bit pat [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int prn, want;
    prn = $urandom_range(31, 0);
    i_code_rate = 32'd0; i_carrier_rate = 32'h4000_0000;
    do_start(prn, 1'b0);
    run_samples(12, -1, 0);
    for (int k = 0; k < 12; k++) begin
      want = (pat[k % 4] ^ ca_tab[prn][0]) ? -AMP : AMP;
      n_checks++;
      if (obs_q[k] != want) $display("FAIL carrier s%0d: got %0d want %0d", k + 1, obs_q[k], want);
      else n_pass++;
    end
  endtask

  task automatic test_enable_gap();
    i_code_rate = $urandom; i_carrier_rate = $urandom;
    do_start($urandom_range(31, 0), 1'($urandom));
    run_samples(40, 15, 7);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      i_code_rate = $urandom; i_carrier_rate = $urandom;
      do_start($urandom_range(31, 0), 1'($urandom));
      run_samples(150, -1, 0);
    end
  endtask

  task automatic test_start_on_tick();
    i_code_rate = $urandom; i_carrier_rate = $urandom;
    do_start($urandom_range(31, 0), 1'b0);
    run_samples(5, -1, 0);
    for (int i = 0; i < SD - 1; i++) begin
      @(posedge clk); #1;
    end
    do_start($urandom_range(31, 0), 1'b1);
    run_samples(6, -1, 0);
  endtask

  task automatic test_reset_mid();
    i_code_rate = 32'h8000_0000; i_carrier_rate = $urandom;
    do_start($urandom_range(31, 1), 1'b1);
    run_samples(9, -1, 0);
    @(posedge clk); #3;
    i_rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid");
    @(negedge clk);
    i_rst_n = 1'b1;
    model_restart(0, 1'b0);
    run_samples(10, -1, 0);
  endtask

  task automatic test_long_epoch_nav();
    nav_alt = 1'b1;
    i_code_rate = 32'hFFFF_FFFF; i_carrier_rate = $urandom;
    do_start($urandom_range(31, 0), 1'b0);
    run_samples(20470, -1, 0);
    nav_alt = 1'b0;
    n_checks++;
    if (first_epoch != 1024) $display("FAIL first_epoch: got sample %0d want 1024", first_epoch);
    else n_pass++;
    n_checks++;
    if (n_nav != 1 || nav_at != 20461) $display("FAIL nav_boundary: got %0d at s%0d want 1 at s20461", n_nav, nav_at);
    else n_pass++;
  endtask

  initial begin
    build_tables();
    nav_alt = 1'b0;
    test_reset();
    test_prn1_pattern();
    test_carrier();
    test_enable_gap();
    test_random();
    test_start_on_tick();
    test_reset_mid();
    test_long_epoch_nav();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
